gen_scheduler: RTL and testbench
================================

# gen_scheduler

Generation scheduler for the Conway datapath. It paces generations from a programmable tick period and sweeps every cell address of the grid to the cell-update engine over a valid/ready handshake. It waits for the engine to drain, then pulses a buffer swap. It sits between the user controls (run/step/period) and the update engine / double-buffered frame store.

## Interface
Parameters:
- GRID_W, 80, grid columns (≥2)
- GRID_H, 60, grid rows (≥2)
- XW, 7, width of cell_x; must hold GRID_W-1
- YW, 6, width of cell_y; must hold GRID_H-1
- TW, 24, width of period and the internal tick timer

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- run  in  1  level; free-running generation mode
- step  in  1  one-cycle pulse; single generation when not running
- period  in  TW  cycles between generations in run mode; 0 treated as 1
- cell_valid  out  1  cell address valid to engine
- cell_ready  in  1  engine accepts address
- cell_x  out  XW  current column
- cell_y  out  YW  current row
- cell_last  out  1  high with cell_valid on cell (GRID_W-1, GRID_H-1)
- eng_idle  in  1  engine pipeline empty
- swap  out  1  one-cycle pulse: flip front/back buffers
- busy  out  1  high in SWEEP, DRAIN, COMMIT
- gen_count  out  16  generations completed (see Configuration)

## Operation
- States: IDLE, WAIT, SWEEP, DRAIN, COMMIT. Reset value is IDLE.
- Outputs at reset: cell_valid=0, cell_x=0, cell_y=0, cell_last=0, swap=0, busy=0, gen_count=0. The tick timer is cleared.
- IDLE: run=1 goes to WAIT and clears the timer. Otherwise step=1 goes to SWEEP. If run and step are both high, run wins and step is dropped.
- WAIT: the timer increments each cycle. When the timer equals max(period,1)-1, go to SWEEP. run=0 goes to IDLE, and this check takes priority over the timer match. step is ignored.
- period is sampled every WAIT cycle. A change mid-wait takes effect immediately. If the timer is already beyond the new terminal value, it continues to count, wraps at 2^TW, and fires on the next match.
- SWEEP: cell_valid=1. The handshake completes on cell_valid & cell_ready. On each handshake:
  - cell_x increments.
  - When cell_x is GRID_W-1, cell_x wraps to 0 and cell_y increments.
  - The handshake on the last cell resets x and y to 0 and goes to DRAIN.
- While cell_ready=0, cell_valid, cell_x and cell_y hold stable.
- Changes to run during SWEEP or DRAIN do not abort the generation.
- DRAIN: cell_valid=0. Go to COMMIT on the first cycle eng_idle=1.
- COMMIT: swap=1 for exactly this cycle. gen_count increments, wrapping at 16 bits. Next state is WAIT (timer cleared) if run=1, else IDLE.
- A step arriving during WAIT, SWEEP, DRAIN or COMMIT is discarded and not queued.
- Reset asserted in any state returns all state and outputs to their reset values on the next edge. A partial sweep is abandoned with no swap.

## Timing
- All outputs are registered.
- step sampled at edge n in IDLE: cell_valid=1 from cycle n+1.
- With cell_ready=1 and eng_idle=1, and N=GRID_W·GRID_H:
  - handshakes occupy cycles n+1 … n+N
  - DRAIN is cycle n+N+1
  - swap=1 in cycle n+N+2
- Run mode with period P, always-ready engine: swap-to-swap interval is P+N+3 cycles (WAIT P, SWEEP N, DRAIN 1, COMMIT 1, transition into WAIT 1).
- DRAIN lasts at least 1 cycle even if eng_idle was already high.

## Configuration
- GEN_SCHED_GEN_COUNT_EN defined: the 16-bit gen_count register is implemented as described above.
- GEN_SCHED_GEN_COUNT_EN not defined: no counter is synthesized and gen_count is constant 0. All other behaviour is identical.

## Test plan
All scenarios use GRID_W=4, GRID_H=3 (N=12), TW=8, with GEN_SCHED_GEN_COUNT_EN defined unless stated.
- Reset then single step, cell_ready=1, eng_idle=1:
  - 12 handshakes in order (0,0),(1,0)…(3,2); cell_last only on (3,2).
  - swap pulses exactly 2 cycles after the last handshake; gen_count=1; back to IDLE, busy=0.
- Backpressure: cell_ready toggles 1,0,0,1… during SWEEP -> address held stable while not ready; exactly 12 accepted addresses, none duplicated or skipped.
- Run with period=5, ready and idle tied high -> swaps at a fixed 20-cycle interval. With period=0 -> 16-cycle interval.
- Drain stall: eng_idle=0 for 7 cycles after the last handshake -> swap occurs in the cycle after eng_idle rises; no cell_valid during DRAIN.
- Control edge cases:
  - run dropped mid-SWEEP -> generation completes, swap occurs, state goes to IDLE.
  - step during SWEEP -> ignored; exactly one swap.
  - run and step together in IDLE -> WAIT entered, no immediate sweep.
- Reset at handshake 6 of 12 -> next cycle cell_valid=0, x=y=0, no swap, gen_count unchanged. With the macro undefined, gen_count stays 0 across 3 generations.

Source files
------------

// File: rtl/gen_scheduler.sv
// Generation scheduler: paces generations from a tick period, sweeps every cell
// address to the update engine over valid/ready, waits for the engine to drain,
// then pulses a front/back buffer swap. Optional generation counter: GEN_SCHED_GEN_COUNT_EN.
module gen_scheduler #(
  parameter int GRID_W = 80,
  parameter int GRID_H = 60,
  parameter int XW     = 7,
  parameter int YW     = 6,
  parameter int TW     = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          step,
  input  logic [TW-1:0] period,
  output logic          cell_valid,
  input  logic          cell_ready,
  output logic [XW-1:0] cell_x,
  output logic [YW-1:0] cell_y,
  output logic          cell_last,
  input  logic          eng_idle,
  output logic          swap,
  output logic          busy,
  output logic [15:0]   gen_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SWEEP  = 3'd2,
    S_DRAIN  = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] term;
  logic          match_q;
  logic          hs;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;

  assign hs = cell_valid & cell_ready;

  // Terminal timer value; a period of 0 behaves as 1.
  always_comb begin
    term = '0;
    if (period != '0) term = period - 1'b1;
  end

  // Next raster position: advance on each accepted address, wrap after the last cell.
  always_comb begin
    x_nxt = cell_x;
    y_nxt = cell_y;
    if (hs) begin
      if (cell_x == X_MAX) begin
        x_nxt = '0;
        y_nxt = (cell_y == Y_MAX) ? '0 : cell_y + 1'b1;
      end else begin
        x_nxt = cell_x + 1'b1;
      end
    end
  end

  // Next-state logic; run beats step in IDLE, and run=0 beats the timer match in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (run)       state_nxt = S_WAIT;
        else if (step) state_nxt = S_SWEEP;
      end
      S_WAIT: begin
        if (!run)         state_nxt = S_IDLE;
        else if (match_q) state_nxt = S_SWEEP;
      end
      S_SWEEP: begin
        if (hs && cell_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (eng_idle) state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        state_nxt = run ? S_WAIT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, tick timer and registered outputs.
  // The timer match is registered, so WAIT spans max(period,1)+1 cycles; this is
  // the extra cycle in the P+N+3 swap-to-swap interval.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      match_q    <= 1'b0;
      cell_valid <= 1'b0;
      cell_x     <= '0;
      cell_y     <= '0;
      cell_last  <= 1'b0;
      swap       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_WAIT && state != S_WAIT) timer <= '0;
      else if (state == S_WAIT)                   timer <= timer + 1'b1;
      match_q    <= (state == S_WAIT) && (state_nxt == S_WAIT) && (timer == term);
      cell_valid <= (state_nxt == S_SWEEP);
      cell_x     <= x_nxt;
      cell_y     <= y_nxt;
      cell_last  <= (state_nxt == S_SWEEP) && (x_nxt == X_MAX) && (y_nxt == Y_MAX);
      swap       <= (state_nxt == S_COMMIT);
      busy       <= (state_nxt == S_SWEEP) || (state_nxt == S_DRAIN) ||
                    (state_nxt == S_COMMIT);
    end
  end

`ifdef GEN_SCHED_GEN_COUNT_EN
  // Completed-generation counter, stepping in the same cycle swap is raised.
  always_ff @(posedge clk) begin
    if (reset)                      gen_count <= '0;
    else if (state_nxt == S_COMMIT) gen_count <= gen_count + 1'b1;
  end
`else
  assign gen_count = '0;
`endif

endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler on a 4x3 grid (N=12), TW=8.
// Outputs are sampled and inputs driven on the falling edge.
module tb_gen_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [7:0] period = 8'd0;
  logic       cell_valid;
  logic       cell_ready = 1'b1;
  logic [1:0] cell_x;
  logic [1:0] cell_y;
  logic       cell_last;
  logic       eng_idle = 1'b1;
  logic       swap;
  logic       busy;
  logic [15:0] gen_count;

  int n_tests = 0;
  int n_fail  = 0;

  int hs_cnt, swap_cnt, last_hs_cyc, first_vld_cyc, drain_vld_bad;
  int swap_cyc[$];

  gen_scheduler #(.GRID_W(4), .GRID_H(3), .XW(2), .YW(2), .TW(8)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .period(period),
    .cell_valid(cell_valid), .cell_ready(cell_ready), .cell_x(cell_x),
    .cell_y(cell_y), .cell_last(cell_last), .eng_idle(eng_idle),
    .swap(swap), .busy(busy), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected gen_count after n completed generations since reset.
  function automatic logic [31:0] gexp(input int n);
`ifdef GEN_SCHED_GEN_COUNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_cycles(2);
    reset = 1'b0;
  endtask

  // Observe ncyc cycles: drive ready/idle, check raster order, hold stability,
  // drain quietness, and record swap cycles (cycle 1 = first cycle after call).
  task automatic watch(input int ncyc, input int rdy_mode, input int stall,
                       input int drop_run_hs, input int step_hs);
    int k = 0;
    int rc = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic rdy;
    logic [1:0] px = 2'd0;
    logic [1:0] py = 2'd0;
    bit in_drain = 1'b0;
    hs_cnt = 0; swap_cnt = 0; last_hs_cyc = -1; first_vld_cyc = -1; drain_vld_bad = 0;
    swap_cyc.delete();
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      step = (step_hs >= 0 && k == step_hs && cell_valid) ? 1'b1 : 1'b0;
      if (drop_run_hs >= 0 && k == drop_run_hs) run = 1'b0;
      if (cell_valid && first_vld_cyc < 0) begin
        first_vld_cyc = c;
        chk("busy_sweep", busy, 1);
      end
      if (pv && !pr) begin
        chk("hold_vld", cell_valid, 1);
        chk("hold_x", cell_x, px);
        chk("hold_y", cell_y, py);
      end
      if (swap) begin
        swap_cnt++;
        swap_cyc.push_back(c);
        in_drain = 1'b0;
      end
      if (in_drain && cell_valid) drain_vld_bad++;
      rdy = (rdy_mode == 0) ? 1'b1 : (rc % 3 == 0);
      if (cell_valid) rc++;
      cell_ready = rdy;
      eng_idle = !(in_drain && c <= last_hs_cyc + stall);
      if (cell_valid && rdy) begin
        chk("addr_x", cell_x, (k % 12) % 4);
        chk("addr_y", cell_y, (k % 12) / 4);
        chk("last", cell_last, (k % 12) == 11);
        k++;
        if (k % 12 == 0) begin
          last_hs_cyc = c;
          in_drain = 1'b1;
        end
      end
      pv = cell_valid; pr = rdy; px = cell_x; py = cell_y;
    end
    hs_cnt = k;
    cell_ready = 1'b1;
    eng_idle = 1'b1;
    step = 1'b0;
  endtask

  initial begin
    int k;
    // Reset state
    idle_cycles(3);
    chk("rst_vld", cell_valid, 0);
    chk("rst_x", cell_x, 0);
    chk("rst_y", cell_y, 0);
    chk("rst_last", cell_last, 0);
    chk("rst_swap", swap, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gen", gen_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single step, always ready / idle
    step = 1'b1;
    watch(30, 0, 0, -1, -1);
    chk("s1_first_vld", first_vld_cyc, 1);
    chk("s1_hs", hs_cnt, 12);
    chk("s1_last_hs_cyc", last_hs_cyc, 12);
    chk("s1_swaps", swap_cnt, 1);
    if (swap_cnt > 0) chk("s1_swap_dly", swap_cyc[0] - last_hs_cyc, 2);
    chk("s1_drain_vld", drain_vld_bad, 0);
    chk("s1_busy_end", busy, 0);
    chk("s1_gen", gen_count, gexp(1));

    // Backpressure 1,0,0 pattern
    step = 1'b1;
    watch(60, 1, 0, -1, -1);
    chk("bp_hs", hs_cnt, 12);
    chk("bp_swaps", swap_cnt, 1);
    if (swap_cnt > 0) chk("bp_swap_dly", swap_cyc[0] - last_hs_cyc, 2);
    chk("bp_gen", gen_count, gexp(2));

    // Drain stall: engine busy 7 cycles after the last handshake
    step = 1'b1;
    watch(40, 0, 7, -1, -1);
    chk("dr_hs", hs_cnt, 12);
    chk("dr_swaps", swap_cnt, 1);
    if (swap_cnt > 0) chk("dr_swap_dly", swap_cyc[0] - last_hs_cyc, 9);
    chk("dr_drain_vld", drain_vld_bad, 0);
    chk("dr_gen", gen_count, gexp(3));

    // Run mode, period 5: first swap at cycle 20, then every 20
    period = 8'd5;
    run = 1'b1;
    watch(80, 0, 0, -1, -1);
    chk("p5_swaps", swap_cnt, 4);
    if (swap_cnt >= 3) begin
      chk("p5_first", swap_cyc[0], 20);
      chk("p5_int1", swap_cyc[1] - swap_cyc[0], 20);
      chk("p5_int2", swap_cyc[2] - swap_cyc[1], 20);
    end
    run = 1'b0;
    period = 8'd0;
    idle_cycles(40);

    // Run mode, period 0 (treated as 1): 16-cycle interval
    run = 1'b1;
    watch(50, 0, 0, -1, -1);
    chk("p0_swaps", swap_cnt, 3);
    if (swap_cnt >= 3) begin
      chk("p0_first", swap_cyc[0], 16);
      chk("p0_int1", swap_cyc[1] - swap_cyc[0], 16);
      chk("p0_int2", swap_cyc[2] - swap_cyc[1], 16);
    end
    run = 1'b0;
    idle_cycles(40);
    do_reset();
    chk("rst2_gen", gen_count, 0);

    // Run dropped mid-sweep: generation completes, then idle
    period = 8'd0;
    run = 1'b1;
    watch(40, 0, 0, 4, -1);
    chk("drop_hs", hs_cnt, 12);
    chk("drop_swaps", swap_cnt, 1);
    chk("drop_busy", busy, 0);
    chk("drop_gen", gen_count, gexp(1));

    // Step during sweep is discarded
    step = 1'b1;
    watch(50, 0, 0, -1, 3);
    chk("stp_hs", hs_cnt, 12);
    chk("stp_swaps", swap_cnt, 1);
    chk("stp_gen", gen_count, gexp(2));

    // run and step together in IDLE: WAIT (6 cycles at P=5), sweep from cycle 7
    period = 8'd5;
    run = 1'b1;
    step = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      step = 1'b0;
      if (c == 1) begin
        chk("rs_busy_c1", busy, 0);
        chk("rs_vld_c1", cell_valid, 0);
      end
      if (c == 6) chk("rs_vld_c6", cell_valid, 0);
      if (c == 7) chk("rs_vld_c7", cell_valid, 1);
    end
    run = 1'b0;
    idle_cycles(30);
    chk("rs_busy_end", busy, 0);
    chk("rs_gen", gen_count, gexp(3));

    // Reset at handshake 6: partial sweep abandoned
    do_reset();
    step = 1'b1;
    k = 0;
    for (int c = 0; c < 30 && k < 6; c++) begin
      @(negedge clk);
      step = 1'b0;
      if (cell_valid && cell_ready) k++;
    end
    chk("mr_reached", k, 6);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_vld", cell_valid, 0);
    chk("mr_x", cell_x, 0);
    chk("mr_y", cell_y, 0);
    chk("mr_swap", swap, 0);
    chk("mr_gen", gen_count, 0);
    reset = 1'b0;
    watch(20, 0, 0, -1, -1);
    chk("mr_no_swap", swap_cnt, 0);
    chk("mr_no_hs", hs_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
